// File: rtl/dct_pkg.sv
// Shared DCT package: coefficient width, block size and lane pack/unpack
// helpers used by the 1-D DCT, the transpose buffer and integration tops.
package dct_pkg;

  localparam int DW    = 22;  // signed coefficient width per lane
  localparam int N     = 8;   // block dimension (rows = cols = lanes)
  localparam int IDX_W = 3;   // row/column index width

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Lane k lives at bits [k*DW +: DW] of the flat bus; the packed array
  // ordering matches that directly, so the casts are pure relabels.
  typedef logic [N-1:0][DW-1:0] lane_vec_t;

  function automatic lane_vec_t unpack_lanes(input logic [N*DW-1:0] flat);
    return lane_vec_t'(flat);
  endfunction

  function automatic logic [N*DW-1:0] pack_lanes(input lane_vec_t lanes);
    return (N*DW)'(lanes);
  endfunction

endpackage

// File: rtl/dct_transpose_bank.sv
// One NxN coefficient register array.
//   clk     : rising-edge clock
//   we      : write wr_data into row wr_row
//   wr_row  : row index for the write
//   wr_data : N lanes, lane k = column k of the row
//   rd_col  : column index for the combinational read
//   rd_data : N lanes, lane r = element (row r, column rd_col)
// Storage is deliberately not reset; validity is tracked by the owner.
module dct_transpose_bank
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [N*DW-1:0]   wr_data,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [N*DW-1:0]   rd_data
);

  // mem[row][col]
  logic [N-1:0][N-1:0][DW-1:0] mem;
  lane_vec_t                   col_lanes;

  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= unpack_lanes(wr_data);
  end

  // Column read: lane r picks its element from row r.
  for (genvar r = 0; r < N; r++) begin : g_lane
    assign col_lanes[r] = mem[r][rd_col];
  end

  assign rd_data = pack_lanes(col_lanes);

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows are written into one bank while the other bank is read out column
// by column, sustaining one row in and one column out per cycle.
//   clk       : rising-edge clock
//   rstn      : synchronous, active-high reset (name shared with DCT design)
//   in_valid  / in_ready  / in_row  : row input handshake, lane k = coef k
//   out_valid / out_ready / out_col : column output, lane r = row r element
//   out_idx   : column index of out_col
//   out_last  : high with the last column of a block
module dct_transpose_buffer
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*DW-1:0]   out_col,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  logic [1:0]             full;
  logic                   wr_sel;
  logic                   rd_sel;
  logic [IDX_W-1:0]       wr_row;
  logic [IDX_W-1:0]       rd_col;

  logic                   wr_fire;
  logic                   rd_fire;
  logic [1:0]             bank_we;
  logic [1:0][N*DW-1:0]   bank_col;

  // in_ready is held low for the whole reset cycle so nothing is
  // accepted into a buffer that is being cleared.
  assign in_ready  = !rstn && !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_idx   = rd_col;
  assign out_last  = out_valid && (rd_col == LAST_IDX);

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (wr_sel == 1'(b));

    dct_transpose_bank u_bank (
      .clk     (clk),
      .we      (bank_we[b]),
      .wr_row  (wr_row),
      .wr_data (in_row),
      .rd_col  (rd_col),
      .rd_data (bank_col[b])
    );
  end

  // Reads come straight from bank registers, so out_col holds steady
  // for as long as rd_sel/rd_col do (i.e. through any stall).
  assign out_col = bank_col[rd_sel];

  // A write needs full[wr_sel]=0 and a read needs full[rd_sel]=1, so on a
  // cycle with both they always touch different bits of full.
  always_ff @(posedge clk) begin
    if (rstn) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      if (wr_fire) begin
        wr_row <= wr_row + 1'b1;
        if (wr_row == LAST_IDX) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (rd_fire) begin
        rd_col <= rd_col + 1'b1;
        if (rd_col == LAST_IDX) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
module tb_dct_transpose_buffer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [175:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [175:0] out_col;
  logic [2:0]   out_idx;
  logic         out_last;

  always #5 clk = ~clk;

  dct_transpose_buffer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  typedef struct {
    logic [175:0] col;
    logic [2:0]   idx;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [21:0]  mblk [8][8];
  int           mrow = 0;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rows_acc = 0;
  int           last_row_cyc = 0;
  int           cols_seen = 0;
  int           last_col_cyc = 0;
  int           mark_cols = 0;
  int           first_fire_cyc = 0;
  int           last_fire_cyc = 0;
  logic         prev_stall = 1'b0;
  logic [175:0] prev_col;
  logic [2:0]   prev_idx;
  bit           stop_tog;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: records accepted rows into a block model (pushing the 8
  // transposed columns once a block completes) and pops/compares every
  // column the DUT hands over. Also checks stall stability.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      q.delete();
      mrow = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_col", out_col, prev_col);
        chk("stall_idx", out_idx, prev_idx);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_col", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("col_data", out_col, e.col);
          chk("col_idx", out_idx, e.idx);
          chk("col_last", out_last, e.last);
        end
        if (cols_seen == mark_cols) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        cols_seen++;
        if (out_last) last_col_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_col   = out_col;
      prev_idx   = out_idx;
      if (in_valid && in_ready) begin
        for (int k = 0; k < 8; k++) mblk[mrow][k] = in_row[k*22 +: 22];
        rows_acc++;
        last_row_cyc = cyc;
        mrow++;
        if (mrow == 8) begin
          for (int c = 0; c < 8; c++) begin
            exp_t e;
            e.col = '0;
            for (int r = 0; r < 8; r++) e.col[r*22 +: 22] = mblk[r][c];
            e.idx  = 3'(c);
            e.last = (c == 7);
            q.push_back(e);
          end
          mrow = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one row and hold it until accepted (bounded).
  task automatic send_row(input logic [175:0] r, output int waited);
    logic acc;
    waited = 0;
    in_valid = 1'b1;
    in_row   = r;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1'b1, 1'b0);
  endtask

  function automatic logic [175:0] seq_row(input int base, input int r);
    logic [175:0] v;
    for (int k = 0; k < 8; k++) v[k*22 +: 22] = 22'(base + 8*r + k);
    return v;
  endfunction

  function automatic logic [175:0] rnd_row();
    logic [175:0] v;
    for (int k = 0; k < 8; k++) v[k*22 +: 22] = 22'($urandom);
    return v;
  endfunction

  function automatic logic [175:0] ext_row(input int r);
    logic [175:0] v;
    for (int k = 0; k < 8; k++) v[k*22 +: 22] = ((r + k) % 2 == 1) ? 22'h1FFFFF : 22'h200000;
    return v;
  endfunction

  initial begin
    int w, wsum, base, n, row17, lc17, mark;
    logic [175:0] exp_c0;
    rstn = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_idx", out_idx, 3'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Single block, row r lane k = 8r+k
    out_ready = 1'b1;
    mark = cols_seen;
    for (int r = 0; r < 8; r++) send_row(seq_row(0, r), w);
    @(negedge clk);
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_idx", out_idx, 3'd0);
    for (int r = 0; r < 8; r++) exp_c0[r*22 +: 22] = 22'(8*r);
    chk("latency_col0", out_col, exp_c0);
    @(posedge clk); #1;
    drain(100);
    chk("single_cols", cols_seen - mark, 8);

    // Four back-to-back blocks
    wsum = 0;
    mark_cols = cols_seen;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++) begin
        send_row(seq_row(64*(b+1), r), w);
        wsum += w;
      end
    drain(100);
    chk("b2b_no_stall", wsum, 0);
    chk("b2b_cols", cols_seen - mark_cols, 32);
    chk("b2b_span", last_fire_cyc - first_fire_cyc, 31);

    // Backpressure: 16 rows fit, then 17th waits for block 0 column 7
    base = rows_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_row = seq_row(4096, rows_acc - base);
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", rows_acc - base, 16);
    chk("bp_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0; row17 = -1; lc17 = 0;
    while (rows_acc - base < 24 && n < 200) begin
      in_row = seq_row(4096, rows_acc - base);
      tick();
      n++;
      if (row17 < 0 && rows_acc - base >= 17) begin
        row17 = last_row_cyc;
        lc17  = last_col_cyc;
      end
    end
    in_valid = 1'b0;
    chk("bp_row17_timing", row17 - lc17, 1);
    drain(200);

    // Random handshakes, 50 blocks
    stop_tog = 1'b0;
    fork
      begin
        while (!stop_tog) begin
          out_ready = 1'($urandom % 2);
          tick();
        end
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) tick();
      send_row(rnd_row(), w);
    end
    drain(800);
    stop_tog = 1'b1;
    tick(); tick();
    out_ready = 1'b1;

    // Reset after 5 rows
    for (int r = 0; r < 5; r++) send_row(seq_row(9000, r), w);
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("rst5_out_valid", out_valid, 1'b0);
    chk("rst5_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    // Reset after 3 columns
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(seq_row(10000, r), w);
    mark = cols_seen;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("rst3_cols", cols_seen - mark, 3);
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("rst3_out_valid", out_valid, 1'b0);
    chk("rst3_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst3_after_valid", out_valid, 1'b0);
    chk("rst3_after_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    mark = cols_seen;
    for (int r = 0; r < 8; r++) send_row(seq_row(20000, r), w);
    drain(100);
    chk("clean_block_cols", cols_seen - mark, 8);

    // Extremes
    for (int r = 0; r < 8; r++) send_row(ext_row(r), w);
    @(negedge clk);
    for (int r = 0; r < 8; r++) exp_c0[r*22 +: 22] = (r % 2 == 1) ? 22'h1FFFFF : 22'h200000;
    chk("ext_col0", out_col, exp_c0);
    @(posedge clk); #1;
    drain(100);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
